// File: rtl/multicycle_cu.sv
// Multi-cycle RV32I control unit: a Moore FSM sequences a shared ALU and a single ready-handshaked memory port.
// Build option CU_TRAP_EN: illegal instructions halt in TRAP until reset; otherwise they retire as NOPs.
module multicycle_cu #(
    parameter int CNT_W     = 32,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 Zero,
    input  logic                 Lt,
    input  logic                 Ltu,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [2:0]           ImmSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [ALUCTRL_W-1:0] ALUctrl,
    output logic [1:0]           ResultSrc,
    output logic                 retire,
    output logic [CNT_W-1:0]     instret,
    output logic                 trap
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011, OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR  = 4'd3, ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JALRADR, S_JUMP, S_UPPER, S_TRAP
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_instret;
    logic             w_legal, w_taken, w_retire;
    logic [3:0]       w_alu_dec, w_alu;
    logic [2:0]       w_imm;

    always_comb begin
        w_legal = 1'b1;
        case (op)
            OP_LOAD:  w_legal = !(funct3 inside {3'b011, 3'b110, 3'b111});
            OP_STORE: w_legal = (funct3 <= 3'b010);
            OP_R:     w_legal = (funct7 == 7'h00) ||
                                (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
            OP_I: begin
                if (funct3 == 3'b001)      w_legal = (funct7 == 7'h00);
                else if (funct3 == 3'b101) w_legal = (funct7 == 7'h00) || (funct7 == 7'h20);
            end
            OP_BR:    w_legal = (funct3[2:1] != 2'b01);
            OP_JALR:  w_legal = (funct3 == 3'b000);
            OP_JAL, OP_LUI, OP_AUIPC: w_legal = 1'b1;
            default:  w_legal = 1'b0;
        endcase
    end

    // funct7[5] is an immediate bit for OP-IMM, so it only picks SUB on register ops
    always_comb begin
        w_alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  w_alu_dec = (op == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_dec = ALU_SLL;
            3'b010:  w_alu_dec = ALU_SLT;
            3'b011:  w_alu_dec = ALU_SLTU;
            3'b100:  w_alu_dec = ALU_XOR;
            3'b101:  w_alu_dec = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_dec = ALU_OR;
            default: w_alu_dec = ALU_AND;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = ~Zero;
            3'b100:  w_taken = Lt;
            3'b101:  w_taken = ~Lt;
            3'b110:  w_taken = Ltu;
            3'b111:  w_taken = ~Ltu;
            default: w_taken = 1'b0;
        endcase
        w_imm = 3'b000;
        case (op)
            OP_STORE:        w_imm = 3'b010;
            OP_BR:           w_imm = 3'b011;
            OP_LUI, OP_AUIPC: w_imm = 3'b100;
            OP_JAL:          w_imm = 3'b101;
            default:         w_imm = 3'b000;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ImmSrc    = 3'b000;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        w_alu     = ALU_ADD;
        ResultSrc = 2'b00;
        w_retire  = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = 2'b10;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ResultSrc = 2'b10;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                ImmSrc  = w_imm;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (!w_legal) begin
`ifdef CU_TRAP_EN
                    w_next   = S_TRAP;
`else
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
`endif
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: w_next = S_MEMADR;
                        OP_R:              w_next = S_EXECR;
                        OP_I:              w_next = S_EXECI;
                        OP_BR:             w_next = S_BRANCH;
                        OP_JAL:            w_next = S_JUMP;
                        OP_JALR:           w_next = S_JALRADR;
                        default:           w_next = S_UPPER;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? 3'b010 : 3'b000;
                w_next  = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                w_alu   = w_alu_dec;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA  = 2'b10;
                w_alu    = ALU_SUB;
                PCWrite  = w_taken;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_JALRADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = S_JUMP;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                w_next  = S_ALUWB;
            end
            S_UPPER: begin
                ImmSrc  = 3'b100;
                ALUSrcB = 2'b01;
                ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
                w_next  = S_ALUWB;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            ImmSrc    = 3'b000;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            w_alu     = ALU_ADD;
            ResultSrc = 2'b00;
            w_retire  = 1'b0;
        end
    end

    assign retire  = w_retire;
    assign ALUctrl = ALUCTRL_W'(w_alu);
    assign instret = rst ? '0 : r_instret;

`ifdef CU_TRAP_EN
    logic r_trap;
    assign trap = rst ? 1'b0 : r_trap;

    always_ff @(posedge clk) begin
        if (rst)                   r_trap <= 1'b0;
        else if (w_next == S_TRAP) r_trap <= 1'b1;
    end
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu (CNT_W=4): table of instructions with per-instruction expectations, an instret scoreboard,
// and hand sequences for reset-during-wait, illegal opcodes and counter wrap.
module tb_multicycle_cu;
    logic       clk = 1'b0;
    logic       rst, Zero, Lt, Ltu, mem_ready;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic       mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, retire, trap;
    logic [2:0] ImmSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] ALUctrl, instret;
    logic [24:0] all_out;

    always #5 clk = ~clk;

    multicycle_cu #(.CNT_W(4), .ALUCTRL_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl), .ResultSrc(ResultSrc), .retire(retire),
        .instret(instret), .trap(trap)
    );

    assign all_out = {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ImmSrc, ALUSrcA,
                      ALUSrcB, ALUctrl, ResultSrc, retire, instret, trap};

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z, lt, ltu;
        int         waits, cyc, rw, pcw;
        logic [3:0] pab, alu3;
        logic [1:0] a3;
        logic [2:0] imm2;
        logic [1:0] rsl;
        int         dmem, we;
    } rec_t;

    rec_t       tbl[$];
    logic [3:0] exp_q[$];
    logic [3:0] mdl_cnt;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                                input logic z, input logic lt, input logic ltu, input int waits,
                                input int cyc, input int rw, input int pcw, input logic [3:0] pab,
                                input logic [3:0] alu3, input logic [1:0] a3, input logic [2:0] imm2,
                                input logic [1:0] rsl, input int dmem, input int we);
        rec_t r;
        r.op = o; r.f3 = f3; r.f7 = f7; r.z = z; r.lt = lt; r.ltu = ltu; r.waits = waits;
        r.cyc = cyc; r.rw = rw; r.pcw = pcw; r.pab = pab; r.alu3 = alu3; r.a3 = a3;
        r.imm2 = imm2; r.rsl = rsl; r.dmem = dmem; r.we = we;
        return r;
    endfunction

    // Entered one time unit after a rising edge with the FSM in FETCH; leaves the same way.
    task automatic run_vec(input rec_t v, input string nm);
        int cyc = 0, rw = 0, pcw = 0, dmem = 0, we = 0, waits;
        logic [3:0] alu3 = '0, pab = '0;
        logic [1:0] a3 = '0, rsl = '0;
        logic [2:0] imm2 = '0;
        bit done = 1'b0;
        op = v.op; funct3 = v.f3; funct7 = v.f7; Zero = v.z; Lt = v.lt; Ltu = v.ltu;
        waits = v.waits;
        mdl_cnt = mdl_cnt + 4'd1;
        exp_q.push_back(mdl_cnt);
        while (!done && cyc < 40) begin
            if (mem_req && AdrSrc && waits > 0) begin
                mem_ready = 1'b0;
                waits--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (cyc == 2) imm2 = ImmSrc;
            if (cyc == 3) begin alu3 = ALUctrl; a3 = ALUSrcA; end
            if (RegWrite) rw++;
            if (PCWrite && cyc > 1) begin pcw++; pab = {ALUSrcA, ALUSrcB}; end
            if (mem_req && AdrSrc) dmem++;
            if (mem_we) we++;
            if (retire) begin done = 1'b1; rsl = ResultSrc; end
            @(posedge clk); #1;
        end
        check({nm, ".cycles"}, cyc, v.cyc);
        check({nm, ".regwrite"}, rw, v.rw);
        check({nm, ".pcwrite"}, pcw, v.pcw);
        check({nm, ".dmem_req"}, dmem, v.dmem);
        check({nm, ".mem_we"}, we, v.we);
        check({nm, ".immsrc"}, int'(imm2), int'(v.imm2));
        check({nm, ".resultsrc"}, int'(rsl), int'(v.rsl));
        check({nm, ".trap"}, int'(trap), 0);
        if (v.cyc >= 3) begin
            check({nm, ".aluctrl"}, int'(alu3), int'(v.alu3));
            check({nm, ".srca"}, int'(a3), int'(v.a3));
        end
        if (v.pcw > 0) check({nm, ".pc_ab"}, int'(pab), int'(v.pab));
        if (exp_q.size() > 0) check({nm, ".instret"}, int'(instret), int'(exp_q.pop_front()));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", int'(all_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_cnt = '0;
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1; op = '0; funct3 = '0; funct7 = '0;
        Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0; mem_ready = 1'b0; mdl_cnt = '0;

        //            op     f3 f7     z lt ltu w | cyc rw pcw pab alu3 a3 imm rsl dmem we
        tbl.push_back(mk(7'h33, 0, 7'h00, 0, 0, 0, 0, 4, 1, 0, 4'h0, 0, 2, 0, 0, 0, 0)); // add
        tbl.push_back(mk(7'h33, 0, 7'h20, 0, 0, 0, 0, 4, 1, 0, 4'h0, 1, 2, 0, 0, 0, 0)); // sub
        tbl.push_back(mk(7'h33, 5, 7'h20, 0, 0, 0, 0, 4, 1, 0, 4'h0, 7, 2, 0, 0, 0, 0)); // sra
        tbl.push_back(mk(7'h33, 3, 7'h00, 0, 0, 0, 0, 4, 1, 0, 4'h0, 9, 2, 0, 0, 0, 0)); // sltu
        tbl.push_back(mk(7'h33, 6, 7'h00, 0, 0, 0, 0, 4, 1, 0, 4'h0, 3, 2, 0, 0, 0, 0)); // or
        tbl.push_back(mk(7'h13, 0, 7'h20, 0, 0, 0, 0, 4, 1, 0, 4'h0, 0, 2, 0, 0, 0, 0)); // addi, imm bit set
        tbl.push_back(mk(7'h13, 5, 7'h20, 0, 0, 0, 0, 4, 1, 0, 4'h0, 7, 2, 0, 0, 0, 0)); // srai
        tbl.push_back(mk(7'h13, 2, 7'h00, 0, 0, 0, 0, 4, 1, 0, 4'h0, 8, 2, 0, 0, 0, 0)); // slti
        tbl.push_back(mk(7'h13, 4, 7'h7F, 0, 0, 0, 0, 4, 1, 0, 4'h0, 2, 2, 0, 0, 0, 0)); // xori
        tbl.push_back(mk(7'h13, 1, 7'h00, 0, 0, 0, 0, 4, 1, 0, 4'h0, 5, 2, 0, 0, 0, 0)); // slli
        tbl.push_back(mk(7'h03, 2, 7'h00, 0, 0, 0, 2, 7, 1, 0, 4'h0, 0, 2, 0, 1, 3, 0)); // lw, 2 waits
        tbl.push_back(mk(7'h03, 4, 7'h00, 0, 0, 0, 0, 5, 1, 0, 4'h0, 0, 2, 0, 1, 1, 0)); // lbu
        tbl.push_back(mk(7'h23, 2, 7'h00, 0, 0, 0, 0, 4, 0, 0, 4'h0, 0, 2, 2, 0, 1, 1)); // sw
        tbl.push_back(mk(7'h23, 0, 7'h00, 0, 0, 0, 1, 5, 0, 0, 4'h0, 0, 2, 2, 0, 2, 2)); // sb, 1 wait
        tbl.push_back(mk(7'h63, 5, 7'h00, 0, 1, 0, 0, 3, 0, 0, 4'h0, 1, 2, 3, 0, 0, 0)); // bge, Lt
        tbl.push_back(mk(7'h63, 6, 7'h00, 0, 0, 1, 0, 3, 0, 1, 4'h8, 1, 2, 3, 0, 0, 0)); // bltu, Ltu
        tbl.push_back(mk(7'h63, 0, 7'h00, 1, 0, 0, 0, 3, 0, 1, 4'h8, 1, 2, 3, 0, 0, 0)); // beq, Zero
        tbl.push_back(mk(7'h63, 1, 7'h00, 1, 0, 0, 0, 3, 0, 0, 4'h0, 1, 2, 3, 0, 0, 0)); // bne, Zero
        tbl.push_back(mk(7'h63, 4, 7'h00, 0, 1, 0, 0, 3, 0, 1, 4'h8, 1, 2, 3, 0, 0, 0)); // blt, Lt
        tbl.push_back(mk(7'h63, 7, 7'h00, 0, 0, 0, 0, 3, 0, 1, 4'h8, 1, 2, 3, 0, 0, 0)); // bgeu, ~Ltu
        tbl.push_back(mk(7'h6F, 0, 7'h00, 0, 0, 0, 0, 4, 1, 1, 4'h6, 0, 1, 5, 0, 0, 0)); // jal
        tbl.push_back(mk(7'h67, 0, 7'h00, 0, 0, 0, 0, 5, 1, 1, 4'h6, 0, 2, 0, 0, 0, 0)); // jalr
        tbl.push_back(mk(7'h37, 0, 7'h00, 0, 0, 0, 0, 4, 1, 0, 4'h0, 0, 3, 4, 0, 0, 0)); // lui
        tbl.push_back(mk(7'h17, 0, 7'h00, 0, 0, 0, 0, 4, 1, 0, 4'h0, 0, 1, 4, 0, 0, 0)); // auipc
`ifndef CU_TRAP_EN
        tbl.push_back(mk(7'h7F, 0, 7'h00, 0, 0, 0, 0, 2, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0)); // bad op
        tbl.push_back(mk(7'h33, 0, 7'h01, 0, 0, 0, 0, 2, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0)); // bad R funct7
        tbl.push_back(mk(7'h33, 1, 7'h20, 0, 0, 0, 0, 2, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0)); // 0x20 with sll
        tbl.push_back(mk(7'h13, 1, 7'h20, 0, 0, 0, 0, 2, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0)); // slli 0x20
        tbl.push_back(mk(7'h63, 2, 7'h00, 0, 0, 0, 0, 2, 0, 0, 4'h0, 0, 0, 3, 0, 0, 0)); // branch f3=010
        tbl.push_back(mk(7'h03, 6, 7'h00, 0, 0, 0, 0, 2, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0)); // load f3=110
        tbl.push_back(mk(7'h23, 3, 7'h00, 0, 0, 0, 0, 2, 0, 0, 4'h0, 0, 0, 2, 0, 0, 0)); // store f3=011
        tbl.push_back(mk(7'h67, 1, 7'h00, 0, 0, 0, 0, 2, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0)); // jalr f3=001
`endif

        @(posedge clk); #1;
        @(negedge clk);
        check("reset_state", int'(all_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("first_fetch", int'({mem_req, AdrSrc, ALUSrcA, ALUSrcB, IRWrite}), int'(7'b1_0_00_10_0));
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("v%0d", i));

`ifdef CU_TRAP_EN
        op = 7'h7F; funct3 = '0; funct7 = '0; mem_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("trap_decode_retire", int'(retire), 0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("trap_hold%0d", k), int'(trap), 1);
            check($sformatf("trap_quiet%0d", k),
                  int'({mem_req, IRWrite, PCWrite, RegWrite, retire}), 0);
            check($sformatf("trap_instret%0d", k), int'(instret), int'(mdl_cnt));
            @(posedge clk); #1;
        end
        do_reset();
        @(negedge clk);
        check("trap_cleared", int'(trap), 0);
        @(posedge clk); #1;
        mdl_cnt = '0;
`endif

        // Reset while FETCH is stalled on memory
        op = 7'h33; funct3 = '0; funct7 = '0; mem_ready = 1'b0;
        @(negedge clk);
        check("fetch_wait_req", int'({mem_req, AdrSrc, IRWrite}), int'(3'b100));
        @(posedge clk); #1;
        @(negedge clk);
        check("fetch_wait_hold", int'({mem_req, AdrSrc, IRWrite}), int'(3'b100));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_fetch", int'(all_out), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_cnt = '0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst", int'({mem_req, instret}), int'(5'b1_0000));
        @(posedge clk); #1;

        // 16 retires on a 4-bit counter must wrap it back to zero
        for (int n = 0; n < 15; n++) run_vec(tbl[0], $sformatf("wrap%0d", n));
        check("instret_pre_wrap", int'(instret), 15);
        run_vec(tbl[0], "wrap15");
        check("instret_wrapped", int'(instret), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
